// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit.
// Opcodes, funct codes, ALU and PC-source selects, FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NOR  = 2'b10;
  localparam logic [1:0] ALU_SLTU = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    C_SUBU = 4'd0,
    C_NOR  = 4'd1,
    C_SLTU = 4'd2,
    C_ADDI = 4'd3,
    C_LW   = 4'd4,
    C_SW   = 4'd5,
    C_BLTZ = 4'd6,
    C_J    = 4'd7,
    C_JR   = 4'd8,
    C_ILL  = 4'd9
  } class_e;

  function automatic logic is_rtype(class_e c);
    return (c == C_SUBU) || (c == C_NOR) ||
           (c == C_SLTU) || (c == C_JR);
  endfunction

  // {alu_src, alu_cntrl} driven during EXEC
  function automatic logic [2:0] exec_ctl(class_e c);
    case (c)
      C_SUBU: return {1'b0, ALU_SUB};
      C_NOR:  return {1'b0, ALU_NOR};
      C_SLTU: return {1'b0, ALU_SLTU};
      C_ADDI,
      C_LW,
      C_SW:   return {1'b1, ALU_ADD};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
// Maps opcode/funct onto an instruction class and a legal flag.
module mc_decode
  import mips_pkg::*;
(
  input  logic [31:0] instruction_i,
  output class_e      cls_o,
  output logic        legal_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       rt;
  logic       unused_bits;

  assign op = instruction_i[31:26];
  assign fn = instruction_i[5:0];
  assign rt = (op == OP_RTYPE);
  assign unused_bits = ^instruction_i[25:6];

  always_comb begin
    cls_o = C_ILL;
    unique case (1'b1)
      rt && fn == FN_SUBU: cls_o = C_SUBU;
      rt && fn == FN_NOR:  cls_o = C_NOR;
      rt && fn == FN_SLTU: cls_o = C_SLTU;
      rt && fn == FN_JR:   cls_o = C_JR;
      op == OP_ADDI:       cls_o = C_ADDI;
      op == OP_LW:         cls_o = C_LW;
      op == OP_SW:         cls_o = C_SW;
      op == OP_BLTZ:       cls_o = C_BLTZ;
      op == OP_J:          cls_o = C_J;
      default:             cls_o = C_ILL;
    endcase
  end

  assign legal_o = (cls_o != C_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM with memory wait timeout.
// Outputs are registered from next state; fetch/branch PC strobes are live.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        alu_neg,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_cntrl,
  output logic        mem_to_reg,
  output logic        illegal
);

  localparam logic [7:0] WMAX = 8'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  class_e     cls_q, cls_d;
  class_e     dec_cls;
  logic       dec_legal;
  logic [7:0] wcnt_q, wcnt_d;
  logic       ill_q, ill_d;

  logic       mem_req_q, mem_we_q, iord_q;
  logic [1:0] pc_src_q;
  logic       reg_wr_q, reg_dst_q, m2r_q;
  logic       alu_src_q;
  logic [1:0] alu_q;
  logic       br_q, jmp_q;

  logic       done;
  logic       waiting;
  logic [2:0] ectl;

  mc_decode u_dec (
    .instruction_i (instruction),
    .cls_o         (dec_cls),
    .legal_o       (dec_legal)
  );

  // mem_ready only counts while a request is actually out
  assign done    = mem_req_q & mem_ready;
  assign waiting = mem_req_q & ~mem_ready;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wcnt_d  = wcnt_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_FETCH:  if (done) state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        unique case (1'b1)
          !dec_legal:         state_d = S_HALT;
          dec_cls == C_BLTZ:  state_d = S_BRANCH;
          dec_cls == C_J,
          dec_cls == C_JR:    state_d = S_JUMP;
          default:            state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (cls_q == C_LW)      state_d = S_MEM_RD;
        else if (cls_q == C_SW) state_d = S_MEM_WR;
        else                    state_d = S_WB;
      end
      S_MEM_RD: if (done) state_d = S_WB;
      S_MEM_WR: if (done) state_d = S_FETCH;
      S_WB,
      S_BRANCH,
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
    if (waiting) begin
      if (wcnt_q + 8'd1 == WMAX) state_d = S_HALT;
      else                       wcnt_d = wcnt_q + 8'd1;
    end
    if (done || state_d != state_q) wcnt_d = '0;
    if (state_d == S_HALT) ill_d = 1'b1;
  end

  assign ectl = exec_ctl(cls_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      wcnt_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wcnt_q  <= wcnt_d;
      ill_q   <= ill_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      iord_q    <= 1'b0;
      pc_src_q  <= PC_PLUS4;
      reg_wr_q  <= 1'b0;
      reg_dst_q <= 1'b0;
      m2r_q     <= 1'b0;
      alu_src_q <= 1'b0;
      alu_q     <= ALU_ADD;
      br_q      <= 1'b0;
      jmp_q     <= 1'b0;
    end else begin
      mem_req_q <= (state_d == S_FETCH) ||
                   (state_d == S_MEM_RD) ||
                   (state_d == S_MEM_WR);
      mem_we_q  <= (state_d == S_MEM_WR);
      iord_q    <= (state_d == S_MEM_RD) ||
                   (state_d == S_MEM_WR);
      reg_wr_q  <= (state_d == S_WB);
      reg_dst_q <= (state_d == S_WB) && is_rtype(cls_d);
      m2r_q     <= (state_d == S_WB) && (cls_d == C_LW);
      alu_src_q <= (state_d == S_EXEC) && ectl[2];
      alu_q     <= (state_d == S_EXEC) ? ectl[1:0] : ALU_ADD;
      br_q      <= (state_d == S_BRANCH);
      jmp_q     <= (state_d == S_JUMP);
      if (state_d == S_BRANCH)
        pc_src_q <= PC_BR;
      else if (state_d == S_JUMP)
        pc_src_q <= (cls_d == C_JR) ? PC_RS : PC_JMP;
      else
        pc_src_q <= PC_PLUS4;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign iord       = iord_q;
  assign ir_write   = (state_q == S_FETCH) & done;
  assign pc_write   = ((state_q == S_FETCH) & done) |
                      (br_q & alu_neg) | jmp_q;
  assign pc_src     = pc_src_q;
  assign reg_wr     = reg_wr_q;
  assign reg_dst    = reg_dst_q;
  assign alu_src    = alu_src_q;
  assign alu_cntrl  = alu_q;
  assign mem_to_reg = m2r_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Expected per-cycle outputs come from an instruction-level timeline model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        alu_neg = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_cntrl;
  logic        reg_wr, reg_dst, alu_src, mem_to_reg, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .mem_ready(mem_ready), .alu_neg(alu_neg),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_cntrl(alu_cntrl), .mem_to_reg(mem_to_reg),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef logic [13:0] vec_t;
  localparam vec_t MREQ   = 14'h2000;
  localparam vec_t MWE    = 14'h1000;
  localparam vec_t IORD   = 14'h0800;
  localparam vec_t IRW    = 14'h0400;
  localparam vec_t PCW    = 14'h0200;
  localparam vec_t PCS_BR = 14'h0080;
  localparam vec_t PCS_J  = 14'h0100;
  localparam vec_t PCS_JR = 14'h0180;
  localparam vec_t RW     = 14'h0040;
  localparam vec_t RD     = 14'h0020;
  localparam vec_t ASRC   = 14'h0010;
  localparam vec_t A_SUB  = 14'h0004;
  localparam vec_t A_NOR  = 14'h0008;
  localparam vec_t A_SLTU = 14'h000C;
  localparam vec_t M2R    = 14'h0002;
  localparam vec_t ILL    = 14'h0001;
  localparam int   MAXW   = 15;

  localparam int M_SUBU = 0, M_NOR = 1, M_SLTU = 2, M_ADDI = 3;
  localparam int M_LW = 4, M_SW = 5, M_BLTZ = 6, M_J = 7;
  localparam int M_JR = 8, M_ILL = 9;

  vec_t exq[$];
  bit   rdq[$];
  bit   dead;

  function automatic vec_t outv();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
            reg_wr, reg_dst, alu_src, alu_cntrl, mem_to_reg, illegal};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(vec_t v, bit r);
    exq.push_back(v);
    rdq.push_back(r);
  endfunction

  // w wait cycles then completion; MAXW waits end in a halted machine
  function automatic void mem_phase(vec_t v, int w, vec_t vd);
    if (w >= MAXW) begin
      for (int i = 0; i < MAXW; i++) push(v, 1'b0);
      for (int i = 0; i < 6; i++) push(ILL, rb());
      dead = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(v, 1'b0);
      push(vd, 1'b1);
    end
  endfunction

  function automatic vec_t exec_v(int m);
    case (m)
      M_SUBU:  return A_SUB;
      M_NOR:   return A_NOR;
      M_SLTU:  return A_SLTU;
      default: return ASRC;
    endcase
  endfunction

  function automatic logic [31:0] enc(int m);
    logic [31:0] r;
    r = $urandom;
    case (m)
      M_SUBU:  return {6'h00, r[25:6], 6'h23};
      M_NOR:   return {6'h00, r[25:6], 6'h27};
      M_SLTU:  return {6'h00, r[25:6], 6'h2B};
      M_JR:    return {6'h00, r[25:6], 6'h08};
      M_ADDI:  return {6'h08, r[25:0]};
      M_LW:    return {6'h23, r[25:0]};
      M_SW:    return {6'h2B, r[25:0]};
      M_BLTZ:  return {6'h01, r[25:0]};
      M_J:     return {6'h02, r[25:0]};
      default: return {6'h3F, r[25:0]};
    endcase
  endfunction

  task automatic run_instr(input string nm, input int m,
                           input logic [31:0] ins, input int fw,
                           input int mw, input logic neg);
    exq.delete();
    rdq.delete();
    dead = 1'b0;
    mem_phase(MREQ, fw, MREQ | IRW | PCW);
    if (!dead) begin
      push('0, rb());
      case (m)
        M_SUBU, M_NOR, M_SLTU, M_ADDI: begin
          push(exec_v(m), rb());
          push(RW | ((m != M_ADDI) ? RD : vec_t'(0)), rb());
        end
        M_LW: begin
          push(exec_v(m), rb());
          mem_phase(MREQ | IORD, mw, MREQ | IORD);
          if (!dead) push(RW | M2R, rb());
        end
        M_SW: begin
          push(exec_v(m), rb());
          mem_phase(MREQ | MWE | IORD, mw, MREQ | MWE | IORD);
        end
        M_BLTZ: push(PCS_BR | (neg ? PCW : vec_t'(0)), rb());
        M_J:    push(PCW | PCS_J, rb());
        M_JR:   push(PCW | PCS_JR, rb());
        default: for (int i = 0; i < 6; i++) push(ILL, rb());
      endcase
    end
    foreach (exq[i]) begin
      @(negedge clk);
      instruction = ins;
      alu_neg = neg;
      mem_ready = rdq[i];
      #1;
      checks++;
      if (outv() !== exq[i]) begin
        errors++;
        $display("FAIL %s cyc%0d: got %h exp %h", nm, i, outv(), exq[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL reset_enter: got %h exp 0", outv());
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outv() !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h exp 0", outv());
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_addi();
    run_instr("addi", M_ADDI, 32'h20080005, 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", M_LW, 32'h8D090004, 0, 3, 1'b0);
    run_instr("lw_wait14", M_LW, 32'h8D090004, 2, 14, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("bltz_taken", M_BLTZ, enc(M_BLTZ), 0, 0, 1'b1);
    run_instr("bltz_not", M_BLTZ, enc(M_BLTZ), 1, 0, 1'b0);
  endtask

  task automatic test_jumps();
    run_instr("jr", M_JR, 32'h01000008, 0, 0, 1'b0);
    run_instr("j", M_J, 32'h08000010, 0, 0, 1'b1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", M_ILL, 32'hFC000000, 0, 0, 1'b0);
    do_reset();
    run_instr("after_ill", M_SUBU, enc(M_SUBU), 0, 0, 1'b0);
    run_instr("fetch_tmo", M_ADDI, enc(M_ADDI), MAXW, 0, 1'b0);
    do_reset();
    run_instr("sw_tmo", M_SW, enc(M_SW), 0, MAXW, 1'b0);
    do_reset();
  endtask

  task automatic test_reset_mid();
    vec_t e[4];
    e[0] = MREQ | IRW | PCW;
    e[1] = '0;
    e[2] = ASRC;
    e[3] = MREQ | MWE | IORD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instruction = enc(M_SW);
      mem_ready = (i == 0);
      #1;
      checks++;
      if (outv() !== e[i]) begin
        errors++;
        $display("FAIL mid_sw cyc%0d: got %h exp %h", i, outv(), e[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, reg_wr} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_drop: got %b exp 000",
               {mem_req, mem_we, reg_wr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (outv() !== MREQ) begin
      errors++;
      $display("FAIL mid_refetch: got %h exp %h", outv(), MREQ);
    end
    run_instr("after_mid", M_LW, enc(M_LW), 0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int m;
      m = $urandom_range(0, 8);
      run_instr($sformatf("rand%0d_m%0d", n, m), m, enc(m),
                $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
